// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: free-running 5-bit counter that produces a divided clock
// (/2 ../32) with glitch-free ratio changes aligned to the counter wrap.
// Optional feature macro: CLK_DIV_CTRL_CNT_EN adds the 8-bit saturating
// switch_cnt output that counts completed ratio changes.
module clk_div_ctrl #(
  parameter logic [2:0] DEFAULT_SEL = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [2:0] sel,
  output logic       ack,
  output logic       err,
  output logic       busy,
  output logic [2:0] cur_sel,
  output logic       div_out,
  output logic       tick
`ifdef CLK_DIV_CTRL_CNT_EN
  ,
  output logic [7:0] switch_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_ALIGN = 2'd1,
    DONE       = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] cur_sel_q, cur_sel_d;
  logic [2:0] pend_sel_q, pend_sel_d;
  logic       div_q, div_d;
  logic       tick_q, tick_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;

  // Counter bit selected by a ratio code; illegal codes never reach here.
  function automatic logic cnt_bit(input logic [4:0] c, input logic [2:0] s);
    case (s)
      3'd0:    cnt_bit = c[0];
      3'd1:    cnt_bit = c[1];
      3'd2:    cnt_bit = c[2];
      3'd3:    cnt_bit = c[3];
      3'd4:    cnt_bit = c[4];
      default: cnt_bit = 1'b0;
    endcase
  endfunction

  // Next-state logic: request handling, wrap-aligned ratio switch, output pulses.
  always_comb begin
    state_d    = state_q;
    pend_sel_d = pend_sel_q;
    cur_sel_d  = cur_sel_q;
    err_d      = 1'b0;
    cnt_d      = cnt_q + 5'd1;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (sel <= 3'd4) begin
            pend_sel_d = sel;
            state_d    = WAIT_ALIGN;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_ALIGN: begin
        // Switch only as cnt wraps to 0: every ratio's output is low then.
        if (cnt_q == 5'd31) begin
          cur_sel_d = pend_sel_q;
          state_d   = DONE;
        end else begin
          state_d = WAIT_ALIGN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ack_d  = (state_d == DONE);
    busy_d = (state_d == WAIT_ALIGN);
    // div_out register tracks the bit of the counter value it will sit beside.
    div_d  = cnt_bit(cnt_d, cur_sel_d);
    tick_d = div_d & ~div_q;
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      cur_sel_q  <= DEFAULT_SEL;
      pend_sel_q <= DEFAULT_SEL;
      div_q      <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_sel_q  <= cur_sel_d;
      pend_sel_q <= pend_sel_d;
      div_q      <= div_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

`ifdef CLK_DIV_CTRL_CNT_EN
  logic [7:0] switch_cnt_q;

  // Count completed ratio changes, saturating at 255.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      switch_cnt_q <= 8'd0;
    end else if (ack_d && (switch_cnt_q != 8'd255)) begin
      switch_cnt_q <= switch_cnt_q + 8'd1;
    end else begin
      switch_cnt_q <= switch_cnt_q;
    end
  end

  assign switch_cnt = switch_cnt_q;
`endif

  assign ack     = ack_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign cur_sel = cur_sel_q;
  assign div_out = div_q;
  assign tick    = tick_q;

endmodule
